// File: rtl/fifo_uart_tx_if.sv
// FIFO read-port bundle between the 32x8 FIFO and its UART transmitter.
// The master side is the consumer that issues READ pops.
interface fifo_uart_tx_if #(
    parameter int size = 8
);
    logic            F_EMPTY_N;
    logic [size-1:0] FIFO_DATA;
    logic            READ;

    modport master (input F_EMPTY_N, input FIFO_DATA, output READ);
    modport slave  (output F_EMPTY_N, output FIFO_DATA, input READ);
endinterface

// File: rtl/fifo_uart_tx.sv
// Drains bytes from the FIFO read port and serializes them as 8N1/8N2 UART
// frames, LSB first, with a fixed four-cycle idle gap between frames.
module fifo_uart_tx #(
    parameter int size      = 8,
    parameter int CLK_DIV   = 434,
    parameter int STOP_BITS = 1
) (
    input  logic           CLOCK,
    input  logic           RESET,
    input  logic           ENABLE,
    fifo_uart_tx_if.master fifo,
    output logic           TX,
    output logic           BUSY,
    output logic           BYTE_DONE
);
    localparam int BAUD_W = $clog2(CLK_DIV);
    localparam int BIT_W  = $clog2(size + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(size - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_LOAD  = 3'd2,
        S_START = 3'd3,
        S_DATA  = 3'd4,
        S_STOP  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t            state_r;
    logic [BAUD_W-1:0] baud_r;
    logic [BIT_W-1:0]  bit_cnt_r;
    logic [size-1:0]   shift_r;
    logic              tx_r;
    logic              read_r;
    logic              byte_done_r;
    logic              baud_wrap_s;

    // A bit period ends on the cycle the baud counter sits at its last value.
    assign baud_wrap_s = (baud_r == BAUD_LAST);

    // Frame sequencer: TX, READ and BYTE_DONE are registered with the next state.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_r     <= S_IDLE;
            baud_r      <= '0;
            bit_cnt_r   <= '0;
            shift_r     <= '0;
            tx_r        <= 1'b1;
            read_r      <= 1'b0;
            byte_done_r <= 1'b0;
        end else begin
            read_r      <= 1'b0;
            byte_done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    tx_r   <= 1'b1;
                    baud_r <= '0;
                    if (ENABLE && fifo.F_EMPTY_N) begin
                        state_r <= S_REQ;
                        read_r  <= 1'b1;
                    end
                end
                S_REQ: begin
                    state_r <= S_LOAD;
                end
                S_LOAD: begin
                    shift_r <= fifo.FIFO_DATA;
                    baud_r  <= '0;
                    tx_r    <= 1'b0;
                    state_r <= S_START;
                end
                S_START: begin
                    if (baud_wrap_s) begin
                        baud_r    <= '0;
                        bit_cnt_r <= '0;
                        tx_r      <= shift_r[0];
                        state_r   <= S_DATA;
                    end else begin
                        baud_r <= baud_r + BAUD_W'(1);
                    end
                end
                S_DATA: begin
                    if (baud_wrap_s) begin
                        baud_r  <= '0;
                        shift_r <= {1'b0, shift_r[size-1:1]};
                        if (bit_cnt_r == DATA_LAST) begin
                            // bit counter is reused to count stop bits
                            bit_cnt_r <= '0;
                            tx_r      <= 1'b1;
                            state_r   <= S_STOP;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                            tx_r      <= shift_r[1];
                        end
                    end else begin
                        baud_r <= baud_r + BAUD_W'(1);
                    end
                end
                S_STOP: begin
                    if (baud_wrap_s) begin
                        baud_r <= '0;
                        if (bit_cnt_r == STOP_LAST) begin
                            byte_done_r <= 1'b1;
                            state_r     <= S_DONE;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                        end
                    end else begin
                        baud_r <= baud_r + BAUD_W'(1);
                    end
                end
                S_DONE: begin
                    tx_r    <= 1'b1;
                    state_r <= S_IDLE;
                end
                default: begin
                    tx_r    <= 1'b1;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign fifo.READ = read_r;
    assign TX        = tx_r;
    assign BYTE_DONE = byte_done_r;
    assign BUSY      = (state_r != S_IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: two instances (1 and 2 stop bits, CLK_DIV=4),
// each fed by a small registered-read FIFO model.
module tb_fifo_uart_tx;
    logic CLOCK = 1'b0;
    logic RESET = 1'b1;
    logic en_a  = 1'b0;
    logic en_b  = 1'b0;
    logic tx_a, busy_a, done_a;
    logic tx_b, busy_b, done_b;
    int   checks = 0;
    int   errors = 0;

    fifo_uart_tx_if #(.size(8)) if_a ();
    fifo_uart_tx_if #(.size(8)) if_b ();

    fifo_uart_tx #(.size(8), .CLK_DIV(4), .STOP_BITS(1)) dut_a (
        .CLOCK(CLOCK), .RESET(RESET), .ENABLE(en_a), .fifo(if_a),
        .TX(tx_a), .BUSY(busy_a), .BYTE_DONE(done_a)
    );
    fifo_uart_tx #(.size(8), .CLK_DIV(4), .STOP_BITS(2)) dut_b (
        .CLOCK(CLOCK), .RESET(RESET), .ENABLE(en_b), .fifo(if_b),
        .TX(tx_b), .BUSY(busy_b), .BYTE_DONE(done_b)
    );

    always #5 CLOCK = ~CLOCK;

    // FIFO models: DATA_OUT updates on the edge that sees READ.
    logic [7:0] mem_a [0:31];
    logic [7:0] mem_b [0:31];
    logic [7:0] dout_a, dout_b;
    int wr_a = 0, rd_a = 0, wr_b = 0, rd_b = 0;

    always_ff @(posedge CLOCK) begin
        if (if_a.READ && (wr_a != rd_a)) begin
            dout_a <= mem_a[rd_a[4:0]];
            rd_a   <= rd_a + 1;
        end
        if (if_b.READ && (wr_b != rd_b)) begin
            dout_b <= mem_b[rd_b[4:0]];
            rd_b   <= rd_b + 1;
        end
    end

    assign if_a.F_EMPTY_N = (wr_a != rd_a);
    assign if_a.FIFO_DATA = dout_a;
    assign if_b.F_EMPTY_N = (wr_b != rd_b);
    assign if_b.FIFO_DATA = dout_b;

    task automatic push_a(input logic [7:0] d);
        mem_a[wr_a[4:0]] = d;
        wr_a = wr_a + 1;
    endtask

    task automatic push_b(input logic [7:0] d);
        mem_b[wr_b[4:0]] = d;
        wr_b = wr_b + 1;
    endtask

    task automatic test_reset();
        logic [7:0] obs;
        RESET = 1'b1;
        repeat (2) @(negedge CLOCK);
        obs = {tx_a, if_a.READ, busy_a, done_a, tx_b, if_b.READ, busy_b, done_b};
        checks++;
        if (obs !== 8'b1000_1000) begin
            errors++;
            $display("FAIL reset_state: got %b expected %b", obs, 8'b1000_1000);
        end
        RESET = 1'b0;
        en_a  = 1'b1;
        en_b  = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            @(negedge CLOCK);
            obs = {tx_a, if_a.READ, busy_a, done_a, tx_b, if_b.READ, busy_b, done_b};
            checks++;
            if (obs !== 8'b1000_1000) begin
                errors++;
                $display("FAIL idle_empty cycle %0d: got %b expected %b", k, obs, 8'b1000_1000);
            end
        end
        en_b = 1'b0;
    endtask

    task automatic test_single_byte();
        logic [9:0] frame;
        int rd_at, fall_at, done_at, n_rd, n_done;
        frame = {1'b1, 8'hA5, 1'b0};
        rd_at = -1; fall_at = -1; done_at = -1; n_rd = 0; n_done = 0;
        push_a(8'hA5);
        for (int k = 1; k <= 60; k++) begin
            @(negedge CLOCK);
            if (if_a.READ === 1'b1) begin n_rd++; if (rd_at < 0) rd_at = k; end
            if (tx_a === 1'b0 && fall_at < 0) fall_at = k;
            if (done_a === 1'b1) begin n_done++; done_at = k; end
            if (k >= 3 && k < 43) begin
                checks++;
                if (tx_a !== frame[(k-3)/4]) begin
                    errors++;
                    $display("FAIL single_tx_bit cycle %0d: got %b expected %b", k, tx_a, frame[(k-3)/4]);
                end
            end
        end
        checks++;
        if (n_rd != 1) begin errors++; $display("FAIL single_read_count: got %0d expected 1", n_rd); end
        checks++;
        if (rd_at != 1) begin errors++; $display("FAIL single_read_latency: got %0d expected 1", rd_at); end
        checks++;
        if (fall_at - rd_at != 2) begin errors++; $display("FAIL single_tx_fall: got %0d expected 2", fall_at - rd_at); end
        checks++;
        if (n_done != 1 || done_at - fall_at != 40) begin
            errors++;
            $display("FAIL single_byte_done: got count %0d offset %0d expected count 1 offset 40", n_done, done_at - fall_at);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] f1, f2;
        int n_rd, n_done, done1, fall2;
        f1 = {1'b1, 8'h00, 1'b0};
        f2 = {1'b1, 8'hFF, 1'b0};
        n_rd = 0; n_done = 0; done1 = -1; fall2 = -1;
        push_a(8'h00);
        push_a(8'hFF);
        for (int k = 1; k <= 120; k++) begin
            @(negedge CLOCK);
            if (if_a.READ === 1'b1) n_rd++;
            if (done_a === 1'b1) begin n_done++; if (done1 < 0) done1 = k; end
            if (done1 > 0 && k > done1 && tx_a === 1'b0 && fall2 < 0) fall2 = k;
            if (k >= 3 && k < 43) begin
                checks++;
                if (tx_a !== f1[(k-3)/4]) begin
                    errors++;
                    $display("FAIL b2b_frame1 cycle %0d: got %b expected %b", k, tx_a, f1[(k-3)/4]);
                end
            end
            if (k >= 47 && k < 87) begin
                checks++;
                if (tx_a !== f2[(k-47)/4]) begin
                    errors++;
                    $display("FAIL b2b_frame2 cycle %0d: got %b expected %b", k, tx_a, f2[(k-47)/4]);
                end
            end
        end
        checks++;
        if (n_rd != 2) begin errors++; $display("FAIL b2b_read_count: got %0d expected 2", n_rd); end
        checks++;
        if (fall2 - done1 != 4) begin errors++; $display("FAIL b2b_gap: got %0d expected 4", fall2 - done1); end
        checks++;
        if (n_done != 2) begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", n_done); end
        checks++;
        if (wr_a - rd_a != 0) begin errors++; $display("FAIL b2b_fifo_empty: got %0d expected 0", wr_a - rd_a); end
    endtask

    task automatic test_enable_drop();
        logic [9:0] frame;
        int n_rd, n_done, done_at;
        frame = {1'b1, 8'h5A, 1'b0};
        n_rd = 0; n_done = 0; done_at = -1;
        push_a(8'h5A); push_a(8'h0F); push_a(8'h22); push_a(8'h33);
        for (int k = 1; k <= 100; k++) begin
            @(negedge CLOCK);
            if (if_a.READ === 1'b1) n_rd++;
            if (done_a === 1'b1) begin n_done++; done_at = k; end
            if (k >= 3 && k < 43) begin
                checks++;
                if (tx_a !== frame[(k-3)/4]) begin
                    errors++;
                    $display("FAIL endrop_tx_bit cycle %0d: got %b expected %b", k, tx_a, frame[(k-3)/4]);
                end
            end
            if (k == 20) en_a = 1'b0;
        end
        checks++;
        if (n_rd != 1) begin errors++; $display("FAIL endrop_read_count: got %0d expected 1", n_rd); end
        checks++;
        if (n_done != 1 || done_at != 43) begin
            errors++;
            $display("FAIL endrop_done: got count %0d at %0d expected count 1 at 43", n_done, done_at);
        end
        checks++;
        if (wr_a - rd_a != 3) begin errors++; $display("FAIL endrop_use_dw: got %0d expected 3", wr_a - rd_a); end
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] frame;
        int n_rd, n_done, done_at;
        frame = {1'b1, 8'h22, 1'b0};
        n_rd = 0; n_done = 0; done_at = -1;
        en_a = 1'b1;
        for (int k = 1; k <= 90; k++) begin
            @(negedge CLOCK);
            if (if_a.READ === 1'b1) n_rd++;
            if (done_a === 1'b1) begin n_done++; if (done_at < 0) done_at = k; end
            if (k == 24) begin
                checks++;
                if (tx_a !== 1'b0 || busy_a !== 1'b1) begin
                    errors++;
                    $display("FAIL rst_pre_bit4: got tx %b busy %b expected tx 0 busy 1", tx_a, busy_a);
                end
                RESET = 1'b1;
            end
            if (k == 25) begin
                checks++;
                if (tx_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0 || if_a.READ !== 1'b0) begin
                    errors++;
                    $display("FAIL rst_abort: got tx %b busy %b done %b read %b expected 1 0 0 0",
                             tx_a, busy_a, done_a, if_a.READ);
                end
                RESET = 1'b0;
            end
            if (k == 26) begin
                checks++;
                if (if_a.READ !== 1'b1) begin errors++; $display("FAIL rst_fresh_read: got %b expected 1", if_a.READ); end
            end
            if (k == 27) en_a = 1'b0;
            if (k >= 28 && k < 68) begin
                checks++;
                if (tx_a !== frame[(k-28)/4]) begin
                    errors++;
                    $display("FAIL rst_fresh_tx cycle %0d: got %b expected %b", k, tx_a, frame[(k-28)/4]);
                end
            end
        end
        checks++;
        if (n_rd != 2 || n_done != 1 || done_at != 68) begin
            errors++;
            $display("FAIL rst_counts: got reads %0d dones %0d first done %0d expected 2 1 68", n_rd, n_done, done_at);
        end
        checks++;
        if (wr_a - rd_a != 1) begin errors++; $display("FAIL rst_use_dw: got %0d expected 1", wr_a - rd_a); end
    endtask

    task automatic test_two_stop();
        logic [10:0] frame;
        int n_rd, n_done, done_at, fall_at;
        frame = {2'b11, 8'h3C, 1'b0};
        n_rd = 0; n_done = 0; done_at = -1; fall_at = -1;
        en_b = 1'b1;
        push_b(8'h3C);
        for (int k = 1; k <= 70; k++) begin
            @(negedge CLOCK);
            if (if_b.READ === 1'b1) n_rd++;
            if (tx_b === 1'b0 && fall_at < 0) fall_at = k;
            if (done_b === 1'b1) begin n_done++; done_at = k; end
            if (k >= 3 && k < 47) begin
                checks++;
                if (tx_b !== frame[(k-3)/4]) begin
                    errors++;
                    $display("FAIL stop2_tx_bit cycle %0d: got %b expected %b", k, tx_b, frame[(k-3)/4]);
                end
            end
        end
        en_b = 1'b0;
        checks++;
        if (n_rd != 1) begin errors++; $display("FAIL stop2_read_count: got %0d expected 1", n_rd); end
        checks++;
        if (n_done != 1 || done_at - fall_at != 44) begin
            errors++;
            $display("FAIL stop2_frame_len: got count %0d length %0d expected count 1 length 44", n_done, done_at - fall_at);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid_frame();
        test_two_stop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
